// File: rtl/mult_div_unit_iter_if.sv
// Handshake and result bundle between EX-stage control and the iterative multiplier.
interface mult_div_unit_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, in1, in2, flush,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, sign, in1, in2, flush,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_iter.sv
// Iterative shift-add 32x32 multiplier (mult/multu) writing a 64-bit product into hi/lo.
// Optional macro MULT_EARLY_TERM_EN ends iteration once the remaining multiplier bits are zero.
module mult_div_unit_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic                  clk,
  input logic                  reset,
  mult_div_unit_iter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   result;
  logic                 last_iter;

  // Magnitudes stay WIDTH-bit unsigned, so the most negative value maps onto itself.
  always_comb begin
    mag1 = (bus.sign && bus.in1[WIDTH-1]) ? (~bus.in1 + WIDTH'(1)) : bus.in1;
    mag2 = (bus.sign && bus.in2[WIDTH-1]) ? (~bus.in2 + WIDTH'(1)) : bus.in2;
    result = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFix) && !bus.flush;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.flush) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag1};
            mplier_q <= mag2;
            neg_q    <= bus.sign & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StCalc: begin
          // mcand_q is pre-shifted each step, equivalent to mcand << counter.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        StFix: begin
          if (!bus.flush) begin
            hi_q <= result[2*WIDTH-1:WIDTH];
            lo_q <= result[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall = (state_q == StIdle) ? bus.start : 1'b1;
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: doc/mult_div_unit_iter.md
Name: mult_div_unit_iter

Overview:
- Iterative 32x32 multiplier in the EX stage, directly downstream of the ALU control decode.
- Consumes the multiply control code (ALUCtl = 5'b11010) and the Sign flag, and produces a 64-bit product into HI/LO.
- Holds the pipeline with a stall output while it iterates.
- Shift-add, one multiplier bit per clock, with sign correction done on magnitudes.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a valid instruction with ALUCtl==5'b11010.
- sign  input  1  1 = signed multiply (mult), 0 = unsigned (multu).
- in1  input  WIDTH  multiplicand (rs).
- in2  input  WIDTH  multiplier (rt).
- flush  input  1  synchronous abort of the current operation.
- stall  output  1  combinational: start & (state==IDLE), or state!=IDLE.
- busy  output  1  registered: state!=IDLE.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WIDTH  upper product half; holds its value until the next completed multiply.
- lo  output  WIDTH  lower product half; holds its value until the next completed multiply.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0, internal registers=0. Reset asserted mid-operation discards the operation; hi/lo return to 0.
- States and transitions:
  - IDLE: if start & ~flush at an edge (edge 0):
    - latch mcand = |in1| and mplier = |in2| when sign=1, else raw values; magnitudes are WIDTH-bit unsigned (0x80000000 maps to 0x80000000).
    - latch neg = sign & (in1[MSB] ^ in2[MSB]).
    - clear acc (2*WIDTH bits) and counter; go to CALC.
  - CALC: each edge:
    - if mplier[0], acc += mcand << counter (unsigned, 2*WIDTH wide, no overflow possible).
    - mplier >>= 1; counter++.
    - at the edge where counter reaches WIDTH-1 (the WIDTH-th CALC edge), go to FIX.
  - FIX: one edge:
    - hi:lo = neg ? (~acc + 1) : acc.
    - done=1 for the following cycle; go to IDLE.
- Latency without the optional feature:
  - start sampled at edge 0; CALC edges 1..WIDTH; FIX at edge WIDTH+1.
  - done is high in the cycle after edge WIDTH+1, i.e. edge 33 for WIDTH=32.
- busy/stall:
  - busy is high from after edge 0 until edge WIDTH+1, where it drops together with done rising.
  - stall is high combinationally in the start cycle and for every busy cycle; it is low in the done cycle, so the instruction advances with valid hi/lo.
- done is cleared at every edge that is not a FIX edge.
- Back-to-back operation: start in the done cycle is accepted (state is IDLE); the new result overwrites hi/lo only at its own FIX edge.
- start while busy: ignored; it does not restart the current operation.
- flush in any state: next state IDLE; hi/lo unchanged; no done pulse. flush wins over a simultaneous start in IDLE.
- Sign=0 with MSB-set operands: treated as unsigned; neg=0.
- Zero operands: still full latency; result 0.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: in CALC, go to FIX at the first edge after which the shifted mplier == 0. Minimum is 1 CALC edge, so a zero multiplier takes CALC at edge 1 and FIX at edge 2. Result values are identical to the full-latency build; only done/busy timing shortens.
- Undefined: fixed WIDTH CALC cycles as specified above.

Test Plan:
- Unsigned 3 * 5, sign=0 -> hi=0x00000000, lo=0x0000000F; done in the cycle after edge 33; stall high in cycles 0..32. With MULT_EARLY_TERM_EN: done after edge 4.
- Signed -3 (0xFFFFFFFD) * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands with sign=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Signed 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000. Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Flush at edge 10 of 7 * 9, with prior hi/lo = 0/0x0F -> no done pulse; hi/lo stay 0/0x0F; busy low after edge 10; a new start at edge 12 completes normally.
- Start re-asserted while busy with different operands -> ignored; the original product is delivered at the original done time. Start in the done cycle -> accepted; second product after another 33 edges.
- Async reset pulsed mid-CALC, not aligned to clk -> busy, done, hi, lo go to 0 immediately; stall is low once start is low.
